// File: rtl/btn_debounce_multi_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_multi_if
//   Button-conditioner signal bundle shared by the debouncer and its user.
//
//   Parameter
//     CH        number of button channels
//
//   Signals (all CH bits wide, one bit per channel)
//     iBtn      raw asynchronous button pins, active-high
//     oLevel    debounced button level
//     oPress    1-cycle pulse on debounced 0->1 (and on auto-repeat)
//     oRelease  1-cycle pulse on debounced 1->0
//     oLong     1-cycle pulse when a press has lasted LONG_TICKS ticks
//     oHeld     high from the oLong pulse until release
//
//   Modports
//     master    the consumer side: drives iBtn, reads the outputs
//     slave     the debouncer side: reads iBtn, drives the outputs
// ---------------------------------------------------------------------------
interface btn_debounce_multi_if #(
  parameter int CH = 5
);
  logic [CH-1:0] iBtn;
  logic [CH-1:0] oLevel;
  logic [CH-1:0] oPress;
  logic [CH-1:0] oRelease;
  logic [CH-1:0] oLong;
  logic [CH-1:0] oHeld;

  modport master (
    output iBtn,
    input  oLevel, oPress, oRelease, oLong, oHeld
  );

  modport slave (
    input  iBtn,
    output oLevel, oPress, oRelease, oLong, oHeld
  );
endinterface

// File: rtl/btn_debounce_multi.sv
// ---------------------------------------------------------------------------
// btn_debounce_multi
//   Multi-channel push-button conditioner. One shared sample-tick divider
//   produces a clock enable; each channel has a 2-FF synchronizer, a
//   tick-enabled SHIFT-bit debounce register with hysteresis, registered
//   press/release pulses and an IDLE/PRESS/HELD long-press FSM.
//
//   Parameters
//     CH            number of channels
//     TICK_DIV      iClk cycles per sample tick (>= 2)
//     SHIFT         equal consecutive samples needed to change level (>= 2)
//     LONG_TICKS    ticks a press must last before oLong fires (>= 1)
//     REPEAT_TICKS  ticks between auto-repeat oPress pulses (>= 1)
//
//   Ports
//     iClk          system clock
//     iRst_n        asynchronous active-low reset
//     bus           btn_debounce_multi_if.slave (iBtn in; oLevel, oPress,
//                   oRelease, oLong, oHeld out)
//
//   Build option
//     BTN_AUTO_REPEAT_EN  when defined, a channel in HELD re-pulses oPress
//                         every REPEAT_TICKS ticks while still pressed.
// ---------------------------------------------------------------------------
module btn_debounce_multi #(
  parameter int CH           = 5,
  parameter int TICK_DIV     = 100_000,
  parameter int SHIFT        = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  btn_debounce_multi_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD
  } state_t;

  // ---------------------------------------------------------------------
  // Shared sample-tick divider
  // ---------------------------------------------------------------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of the others regardless of order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)     r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // ---------------------------------------------------------------------
  // Synchronizer, free-running on every iClk
  // ---------------------------------------------------------------------
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.iBtn;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel debounce, edge and long-press state
  // ---------------------------------------------------------------------
  logic [SHIFT-1:0] r_shift      [CH];
  logic [SHIFT-1:0] w_shift_next [CH];
  state_t           r_state      [CH];
  logic [HW-1:0]    r_hold_cnt   [CH];

  logic [CH-1:0] r_level;
  logic [CH-1:0] r_press;
  logic [CH-1:0] r_release;
  logic [CH-1:0] r_long;
  logic [CH-1:0] r_held;
  logic [CH-1:0] w_level_next;
  logic [CH-1:0] w_repeat;

  // Level changes only on a tick whose shifted-in window is unanimous;
  // a mixed window keeps the old level (hysteresis).
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_shift_next[c] = {r_shift[c][SHIFT-2:0], r_sync2[c]};
      w_level_next[c] = r_level[c];
      if (w_tick && (&w_shift_next[c]))       w_level_next[c] = 1'b1;
      else if (w_tick && !(|w_shift_next[c])) w_level_next[c] = 1'b0;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] r_rep_cnt [CH];

  always_comb begin
    w_repeat = '0;
    for (int c = 0; c < CH; c++) begin
      w_repeat[c] = (r_state[c] == S_HELD) && w_tick && w_level_next[c] &&
                    (r_rep_cnt[c] == REP_LAST);
    end
  end

  // Held at zero outside HELD, so it starts from zero on every entry.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int c = 0; c < CH; c++) r_rep_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if ((r_state[c] != S_HELD) || !w_level_next[c]) r_rep_cnt[c] <= '0;
        else if (w_repeat[c])                            r_rep_cnt[c] <= '0;
        else if (w_tick)                                 r_rep_cnt[c] <= r_rep_cnt[c] + RW'(1);
      end
    end
  end
`else
  assign w_repeat = '0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_held    <= '0;
      // NOTE: the shift registers are reset too, so a button held through
      // reset must re-qualify with a full window of samples.
      for (int c = 0; c < CH; c++) begin
        r_shift[c]    <= '0;
        r_state[c]    <= S_IDLE;
        r_hold_cnt[c] <= '0;
      end
    end else begin
      r_level   <= w_level_next;
      r_press   <= (w_level_next & ~r_level) | w_repeat;
      r_release <= ~w_level_next & r_level;
      r_long    <= '0;
      for (int c = 0; c < CH; c++) begin
        if (w_tick) r_shift[c] <= w_shift_next[c];
        // The FSM follows the next level so oHeld falls in the same cycle
        // oRelease rises.
        case (r_state[c])
          S_IDLE: begin
            if (w_level_next[c]) begin
              r_state[c]    <= S_PRESS;
              r_hold_cnt[c] <= '0;
            end
          end
          S_PRESS: begin
            if (!w_level_next[c]) begin
              r_state[c] <= S_IDLE;
            end else if (w_tick) begin
              if (r_hold_cnt[c] == HOLD_LAST) begin
                r_state[c] <= S_HELD;
                r_long[c]  <= 1'b1;
                r_held[c]  <= 1'b1;
              end
              if (r_hold_cnt[c] != HOLD_MAX) r_hold_cnt[c] <= r_hold_cnt[c] + HW'(1);
            end
          end
          S_HELD: begin
            if (!w_level_next[c]) begin
              r_state[c] <= S_IDLE;
              r_held[c]  <= 1'b0;
            end
          end
          default: begin
            r_state[c] <= S_IDLE;
            r_held[c]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.oLevel   = r_level;
  assign bus.oPress   = r_press;
  assign bus.oRelease = r_release;
  assign bus.oLong    = r_long;
  assign bus.oHeld    = r_held;

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Multi-channel button conditioner; successor to the single-channel debouncer. Sits between raw Basys3 push-button pins and the clock/FSM control logic.
- Per channel:
  - 2-FF input synchronizer
  - tick-enabled shift-register debounce with hysteresis
  - press/release edge pulses
  - long-press detection
- One shared sample-tick divider. Clock enables only, no derived clocks.

Parameters:
- CH, 5, number of button channels
- TICK_DIV, 100_000, iClk cycles per sample tick (≥2)
- SHIFT, 10, consecutive equal samples required to change debounced level (≥2)
- LONG_TICKS, 1000, sample ticks a debounced press must persist before oLong fires (≥1)
- REPEAT_TICKS, 200, sample ticks between auto-repeat pulses (≥1; used only with the optional feature)

Ports:
- iClk, in, 1, system clock
- iRst_n, in, 1, asynchronous active-low reset
- iBtn, in, CH, raw asynchronous button inputs, active-high
- oLevel, out, CH, debounced button level
- oPress, out, CH, 1-cycle pulse on debounced 0→1
- oRelease, out, CH, 1-cycle pulse on debounced 1→0
- oLong, out, CH, 1-cycle pulse when a press reaches LONG_TICKS
- oHeld, out, CH, high from the oLong pulse until release

Behaviour:
- Reset: while iRst_n=0, all flops clear asynchronously: synchronizers, shift regs, tick counter, hold counters, FSMs. Every output is 0. Deassertion is synchronous to iClk via existing top-level reset logic.
- Tick divider:
  - Counter runs 0..TICK_DIV-1.
  - Tick is a 1-cycle enable asserted in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
  - First tick occurs TICK_DIV cycles after reset release.
- Synchronizer: 2 flops per channel on every iClk, not only on ticks.
- Debounce:
  - On each tick, the per-channel SHIFT-bit register shifts in the synchronized bit.
  - Level sets to 1 when all SHIFT bits are 1 and clears to 0 when all are 0. Otherwise it holds (hysteresis).
  - Level is registered. oLevel updates the cycle after the qualifying tick.
- Edge pulses:
  - oPress and oRelease are high for exactly one iClk cycle, the cycle where oLevel has just changed.
  - They are registered against the previous oLevel and are never both high on one channel.
- Per-channel FSM, states IDLE, PRESS, HELD:
  - IDLE: level 1 → PRESS, hold counter cleared.
  - PRESS: hold counter increments on each tick.
    - When it reaches LONG_TICKS → HELD, and oLong pulses for 1 cycle.
    - Level 0 first → IDLE, oLong never fires.
  - HELD: oHeld=1. Level 0 → IDLE, oHeld drops in the same cycle oRelease pulses.
- Hold counter width is $clog2(LONG_TICKS+1). It saturates and never wraps.
- Channels are fully independent. Simultaneous events on different channels all produce their own pulses in the same cycle.
- Reset mid-press forces IDLE. A button still held at release of reset must re-qualify through the full SHIFT samples before oPress fires.
- Nominal press latency from a stable iBtn edge: 2 sync cycles + up to SHIFT ticks + 1 cycle.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a per-channel repeat counter counts ticks.
  - Every REPEAT_TICKS ticks, oPress pulses again for 1 cycle while the level stays 1. The first repeat comes REPEAT_TICKS ticks after oLong.
  - The counter clears on entry to HELD and on release.
- Not defined: no repeat logic is synthesized, and oPress fires exactly once per debounced press.

Test Plan:
- Test parameters: CH=2, TICK_DIV=4, SHIFT=3, LONG_TICKS=5, REPEAT_TICKS=2.
- Reset check: iRst_n=0 asserted mid-stream with iBtn=2'b11 → all outputs 0 immediately. After release, oPress[0] fires only after ≥3 ticks of stable 1.
- Bounce rejection: iBtn[0] toggles 1,0,1 on successive ticks, then holds 0 → oLevel[0] stays 0, no oPress.
- Clean press/release: iBtn[0]=1 for 4 ticks, then 0 for 4 ticks → oLevel[0] 0→1, one oPress[0] pulse. Later one oRelease[0] pulse, each exactly 1 cycle wide.
- Long press: iBtn[1] held 12 ticks → oPress[1] once. oLong[1] one pulse 5 ticks after oLevel rises. oHeld[1]=1 until release, dropping with oRelease[1]. Channel 0 outputs unaffected throughout.
- Short press: iBtn[0] held 4 ticks after qualifying, then released → oPress and oRelease seen, oLong[0] never asserted.
- Auto-repeat (BTN_AUTO_REPEAT_EN defined): hold iBtn[0] for 10 ticks after oLong → oPress[0] pulses every 2 ticks, 5 extra pulses. Same stimulus with the macro undefined → zero extra pulses.
